// File: rtl/clock_pkg.sv
// clock_pkg: mode encodings and shared clock constants for the digital-clock timebase.
package clock_pkg;
    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FAST   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;
    localparam int CLK_HZ_DEFAULT = 100_000_000;
endpackage

// File: rtl/period_counter.sv
// period_counter: wrapping counter that pulses tick for one cycle when it passes its terminal value.
module period_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tick
);
    logic [W-1:0] count_d, count_q;
    logic         tick_d, tick_q, wrap;

    // >= rather than == so a smaller terminal chosen mid-period wraps at once
    always_comb begin
        wrap    = count_q >= term;
        count_d = clr ? '0 : !en ? count_q : wrap ? '0 : count_q + 1'b1;
        tick_d  = !clr && en && wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
endmodule

// File: rtl/tick_generator.sv
// tick_generator: seconds tick with normal/fast/step/hold modes, display-scan tick and set-mode blink level.
module tick_generator import clock_pkg::*; #(
    parameter int CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int SCAN_HZ  = 1000,
    parameter int FAST_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step,
    input  logic       sync_clr,
    output logic       tick_1s,
    output logic       tick_scan,
    output logic       blink
);
    localparam int CNT_W  = $clog2(CLK_HZ);
    localparam int SCAN_P = CLK_HZ / SCAN_HZ;
    localparam int SCAN_W = $clog2(SCAN_P);
    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] HALF_N = CNT_W'(CLK_HZ / 2);
    localparam logic [CNT_W-1:0] LAST_F = CNT_W'(CLK_HZ / FAST_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_F = CNT_W'(CLK_HZ / FAST_DIV / 2);

    logic             fast, run, sec_tick;
    logic [CNT_W-1:0] sec_last, sec_half, sec_count;
    logic [SCAN_W-1:0] scan_count_unused;
    logic             step_tick_d, step_tick_q;
    logic             blink_d, blink_q;

    // Terminal values are passed as TERM-1 so they always fit in CNT_W bits
    always_comb begin
        fast        = mode == MODE_FAST;
        run         = en && (mode == MODE_NORMAL || fast);
        sec_last    = fast ? LAST_F : LAST_N;
        sec_half    = fast ? HALF_F : HALF_N;
        step_tick_d = en && !sync_clr && mode == MODE_STEP && step;
        blink_d     = sync_clr || (run ? (sec_count >= sec_last || sec_count + 1'b1 < sec_half) : blink_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_tick_q <= 1'b0;
            blink_q     <= 1'b1;
        end else begin
            step_tick_q <= step_tick_d;
            blink_q     <= blink_d;
        end
    end

    period_counter #(.W(CNT_W)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (run),
        .clr   (sync_clr),
        .term  (sec_last),
        .count (sec_count),
        .tick  (sec_tick)
    );

    period_counter #(.W(SCAN_W)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (1'b0),
        .term  (SCAN_W'(SCAN_P - 1)),
        .count (scan_count_unused),
        .tick  (tick_scan)
    );

    assign tick_1s = sec_tick | step_tick_q;
    assign blink   = blink_q;
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: directed scenarios plus random traffic checked cycle by cycle against a behavioural model.
module tb_tick_generator;
    import clock_pkg::*;
    localparam int CLK_HZ   = 20;
    localparam int SCAN_HZ  = 5;
    localparam int FAST_DIV = 4;
    localparam int SCAN_P   = CLK_HZ / SCAN_HZ;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, step = 1'b0, sync_clr = 1'b0;
    logic [1:0] mode = MODE_NORMAL;
    logic       tick_1s, tick_scan, blink;

    int   passed = 0, total = 0;
    int   m_el = 0, m_sc = 0;
    logic m_t1 = 1'b0, m_ts = 1'b0, m_bl = 1'b1;
    int   n, first, last, c;
    logic bl_before;

    tick_generator #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .FAST_DIV(FAST_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .step      (step),
        .sync_clr  (sync_clr),
        .tick_1s   (tick_1s),
        .tick_scan (tick_scan),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // m_el = cycles elapsed in the current second; a second completes after term cycles
    task automatic model_step;
        int term;
        term = (mode == MODE_FAST) ? CLK_HZ / FAST_DIV : CLK_HZ;
        if (rst) begin
            m_el = 0; m_sc = 0; m_t1 = 0; m_ts = 0; m_bl = 1;
            return;
        end
        if (sync_clr) begin
            m_el = 0; m_t1 = 0; m_bl = 1;
        end else if (!en || mode == MODE_HOLD) begin
            m_t1 = 0;
        end else if (mode == MODE_STEP) begin
            m_t1 = step;
        end else begin
            m_t1 = (m_el + 1 >= term);
            m_el = m_t1 ? 0 : m_el + 1;
            m_bl = m_el < term / 2;
        end
        if (!en) m_ts = 0;
        else begin
            m_ts = (m_sc + 1 >= SCAN_P);
            m_sc = m_ts ? 0 : m_sc + 1;
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        model_step();
        #1;
        chk("tick_1s", tick_1s, m_t1);
        chk("tick_scan", tick_scan, m_ts);
        chk("blink", blink, m_bl);
    endtask

    task automatic run(input int k, output int nt, output int ft, output int lt);
        nt = 0; ft = -1; lt = -1;
        for (int i = 1; i <= k; i++) begin
            cyc();
            if (tick_1s) begin
                nt++;
                if (ft < 0) ft = i;
                lt = i;
            end
        end
    endtask

    task automatic until_el(input int v);
        for (int i = 0; i < 100 && m_el != v; i++) cyc();
        if (m_el != v) begin
            total++;
            $error("FAIL reach_count: got %0d, expected %0d", m_el, v);
        end
    endtask

    task automatic ticks_until(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!tick_1s && cnt < 100);
    endtask

    initial begin
        en = 1'b1;
        cyc(); cyc();
        chk("rst_tick_1s", tick_1s, 0);
        chk("rst_tick_scan", tick_scan, 0);
        chk("rst_blink", blink, 1);
        rst = 1'b0;
        run(65, n, first, last);
        chk("normal_ticks", n, 3);
        chk("normal_first", first, 20);
        chk("normal_last", last, 60);
        mode = MODE_FAST;
        run(30, n, first, last);
        chk("fast_ticks", n, 6);
        chk("fast_first", first, 1);
        mode = MODE_NORMAL;
        until_el(12);
        mode = MODE_FAST;
        cyc();
        chk("switch_tick", tick_1s, 1);
        run(10, n, first, last);
        chk("switch_ticks", n, 2);
        chk("switch_first", first, 5);
        mode = MODE_NORMAL;
        until_el(3);
        bl_before = m_bl;
        mode = MODE_HOLD;
        run(50, n, first, last);
        chk("hold_ticks", n, 0);
        chk("hold_blink", blink, bl_before);
        mode = MODE_STEP;
        c = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            cyc();
            chk("step_tick", tick_1s, 1);
            step = 1'b0;
            run(6, n, first, last);
            c += n;
        end
        chk("step_extra_ticks", c, 0);
        mode = MODE_NORMAL;
        until_el(15);
        en = 1'b0;
        run(10, n, first, last);
        chk("en_off_ticks", n, 0);
        en = 1'b1;
        ticks_until(c);
        chk("reenable_latency", c, 5);
        until_el(19);
        sync_clr = 1'b1;
        cyc();
        chk("clr_no_tick", tick_1s, 0);
        chk("clr_blink", blink, 1);
        sync_clr = 1'b0;
        ticks_until(c);
        chk("clr_latency", c, 20);
        until_el(11);
        chk("mid_blink", blink, 0);
        rst = 1'b1;
        cyc();
        chk("midrst_tick_1s", tick_1s, 0);
        chk("midrst_tick_scan", tick_scan, 0);
        chk("midrst_blink", blink, 1);
        rst = 1'b0;
        ticks_until(c);
        chk("midrst_latency", c, 20);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            en       = $urandom_range(0, 9) != 0;
            step     = $urandom_range(0, 3) == 0;
            sync_clr = $urandom_range(0, 29) == 0;
            rst      = $urandom_range(0, 199) == 0;
            cyc();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Parametrised timebase generator for the digital clock, placed between the board clock and the time-keeping counters and display driver.
- Produces the 1 Hz seconds tick with selectable rate modes: normal, fast (for time-setting and simulation), hold, and single-step.
- Also produces an independent display-scan tick and a registered blink level for flashing digits during set mode.
- Supports phase re-alignment through a synchronous clear.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz; must be divisible by SCAN_HZ and FAST_DIV.
- SCAN_HZ, 1000, rate of tick_scan in Hz; CLK_HZ/SCAN_HZ >= 2.
- FAST_DIV, 100, speed-up factor in fast mode; CLK_HZ/FAST_DIV >= 2.
- CNT_W, $clog2(CLK_HZ), width of the seconds counter (derived; not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global count enable; low freezes both counters
- mode  in  2  00 NORMAL, 01 FAST, 10 STEP, 11 HOLD
- step  in  1  single-cycle pulse; honoured only in STEP mode with en=1
- sync_clr  in  1  restart seconds phase (counter to 0)
- tick_1s  out  1  one-cycle pulse per (possibly accelerated) second
- tick_scan  out  1  one-cycle pulse at SCAN_HZ
- blink  out  1  registered level, high during first half of each seconds period

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over everything else.
  - Seconds counter=0, scan counter=0, tick_1s=0, tick_scan=0, blink=1.
- Terminal count, selected combinationally from mode each cycle:
  - TERM = CLK_HZ in NORMAL.
  - TERM = CLK_HZ/FAST_DIV in FAST.
  - TERM = CLK_HZ in STEP and HOLD; this value only governs blink, which is frozen in those modes.
- Seconds counter, NORMAL/FAST with en=1:
  - If count >= TERM-1: count<=0 and tick_1s<=1.
  - Otherwise: count<=count+1 and tick_1s<=0.
  - The >= compare handles a switch FAST->NORMAL or NORMAL->FAST mid-period: at most one tick is issued, then the counter wraps. No count is lost and no double tick occurs.
- Latency: after rst deasserts, the first tick_1s is high in the cycle following edge TERM. Thereafter tick_1s pulses exactly every TERM cycles, high for 1 cycle.
- HOLD:
  - Counter frozen, tick_1s=0, blink holds its value.
- STEP:
  - Counter frozen, blink frozen.
  - tick_1s<=step, so a step pulse produces a tick_1s one cycle later.
  - step held high for k cycles yields k ticks; this is defined behaviour.
- step in any other mode: ignored.
- sync_clr (priority below rst, above en):
  - Seconds counter<=0, tick_1s<=0, blink<=1.
  - Scan counter unaffected.
  - sync_clr coinciding with the terminal count suppresses that tick.
- en=0:
  - Both counters frozen, tick_1s=0, tick_scan=0, blink holds.
  - sync_clr is still honoured.
- Scan counter:
  - Period SCAN_P = CLK_HZ/SCAN_HZ.
  - Counts whenever en=1, independent of mode.
  - Same wrap/tick rule as the seconds counter, with fixed terminal SCAN_P-1.
- blink: registered as (next_count < TERM/2) on each cycle the seconds counter advances.
- Width rules:
  - All compares are unsigned at CNT_W.
  - TERM and TERM/2 are computed in CNT_W bits.
  - No overflow is possible because count never exceeds TERM-1 <= CLK_HZ-1.
- Simultaneous events: tick_1s and tick_scan may assert in the same cycle; there is no interaction between them.

Decomposition:
- Package clock_pkg holds:
  - mode encodings MODE_NORMAL, MODE_FAST, MODE_STEP, MODE_HOLD as 2-bit localparams;
  - a shared default CLK_HZ constant used by all clock-domain blocks.
- Sub-module period_counter: parameter W; inputs clk, rst, en, clr, term[W-1:0]; outputs count, tick.
  - Instantiated twice: seconds counter with run-time term, scan counter with constant term.
- STEP/HOLD muxing and blink logic live in the top.

Test Plan (CLK_HZ=20, SCAN_HZ=5, FAST_DIV=4, so TERM normal=20, fast=5, SCAN_P=4):
- Reset, then NORMAL en=1 for 65 cycles -> tick_1s high in cycles 20, 40, 60 only; tick_scan every 4 cycles; blink high cycles 1-9, low 10-19 of each period.
- FAST for 30 cycles -> tick_1s every 5 cycles; switch to NORMAL at count=12 with TERM 20 -> ticks continue counting to 19 without a spurious tick. Switch NORMAL->FAST at count=12 -> exactly one tick next cycle, then period 5.
- HOLD 50 cycles -> tick_1s stays 0, blink constant, tick_scan still every 4. Then STEP with 3 step pulses spaced 7 cycles -> exactly 3 tick_1s, each 1 cycle after its step.
- en=0 for 10 cycles at seconds count=15 -> no ticks; on re-enable the next tick_1s arrives 5 cycles later.
- sync_clr at seconds count=19 -> no tick that cycle; next tick 20 cycles later; scan phase unchanged.
- rst asserted mid-period (count=11, blink=0) -> next cycle all outputs at reset values; next tick 20 cycles after rst release.
